// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: turns one MEM-stage request into one or two word-aligned
// memory transactions, with lane-positioned store data and extended load results.
module lsu_mem_initiator #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DM_ADDRESS-1:0] a,
  input  logic [DATA_W-1:0]     wd,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     rd,
  output logic                  resp_err,
  output logic [31:0]           mem_raddress,
  output logic [31:0]           mem_waddress,
  output logic [31:0]           mem_datain,
  output logic [3:0]            mem_wr,
  input  logic [31:0]           mem_dataout
);

  typedef enum logic [2:0] {IDLE, RD0, WT0, RD1, WT1, WR0, WR1, RESP} state_t;

  localparam logic [DM_ADDRESS-1:0] WORD_STEP = DM_ADDRESS'(4);

  state_t state_reg, state_next;

  logic                  is_load_reg, is_load_next;
  logic [2:0]            f3_reg, f3_next;
  logic [1:0]            off_reg, off_next;
  logic [DM_ADDRESS-1:0] w0_reg, w0_next;
  logic [DATA_W-1:0]     wd_reg, wd_next;
  logic [31:0]           word0_reg, word0_next;

  logic [31:0]           mem_raddress_reg, mem_raddress_next;
  logic [31:0]           mem_waddress_reg, mem_waddress_next;
  logic [31:0]           mem_datain_reg, mem_datain_next;
  logic [3:0]            mem_wr_reg, mem_wr_next;
  logic [DATA_W-1:0]     rd_reg, rd_next;
  logic                  resp_err_reg, resp_err_next;

  logic                  accept;
  logic                  ld_f3_ok, st_f3_ok, req_err;
  logic [2:0]            size_bytes;
  logic [3:0]            end_lane;
  logic                  misaligned;
  logic [DM_ADDRESS-1:0] w1_next;
  logic [7:0]            lane8;
  logic [4:0]            shamt_next, shamt_reg;
  logic [2*DATA_W-1:0]   data64;
  logic [63:0]           ld_pair;
  logic [31:0]           ld_word;
  logic [DATA_W-1:0]     ld_ext;

  assign accept = req_valid && (state_reg == IDLE);

  // Request legality is judged on the live inputs, only at accept time.
  always_comb begin
    ld_f3_ok = Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    st_f3_ok = Funct3 inside {3'b000, 3'b001, 3'b010};
    req_err  = (MemRead == MemWrite) || (MemRead && !ld_f3_ok) || (MemWrite && !st_f3_ok);
  end

  // Request fields are latched once; everything downstream reads the *_next view
  // so the accept edge and the later states share one set of derivations.
  always_comb begin
    is_load_next = is_load_reg;
    f3_next      = f3_reg;
    off_next     = off_reg;
    w0_next      = w0_reg;
    wd_next      = wd_reg;
    if (accept) begin
      is_load_next = MemRead;
      f3_next      = Funct3;
      off_next     = a[1:0];
      w0_next      = {a[DM_ADDRESS-1:2], 2'b00};
      wd_next      = wd;
    end
  end

  always_comb begin
    case (f3_next[1:0])
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
    end_lane   = {2'b00, off_next} + {1'b0, size_bytes};
    misaligned = end_lane > 4'd4;
    w1_next    = w0_next + WORD_STEP;
    shamt_next = {off_next, 3'b000};
    shamt_reg  = {off_reg, 3'b000};
    data64     = {{DATA_W{1'b0}}, wd_next} << shamt_next;
  end

  // Lanes 0-3 belong to word W0, lanes 4-7 spill into word W1.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      localparam logic [3:0] LANE = 4'(gi);
      assign lane8[gi] = (LANE >= {2'b00, off_next}) && (LANE < end_lane);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (req_err)      state_next = RESP;
          else if (MemRead) state_next = RD0;
          else              state_next = WR0;
        end
      end
      RD0:     state_next = WT0;
      WT0:     state_next = misaligned ? RD1 : RESP;
      RD1:     state_next = WT1;
      WT1:     state_next = RESP;
      WR0:     state_next = misaligned ? WR1 : RESP;
      WR1:     state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory-side outputs are registered from the state being entered.
  always_comb begin
    mem_raddress_next = mem_raddress_reg;
    mem_waddress_next = mem_waddress_reg;
    mem_datain_next   = '0;
    mem_wr_next       = '0;
    case (state_next)
      RD0: mem_raddress_next = {{(32-DM_ADDRESS){1'b0}}, w0_next};
      RD1: mem_raddress_next = {{(32-DM_ADDRESS){1'b0}}, w1_next};
      WR0: begin
        mem_waddress_next = {{(32-DM_ADDRESS){1'b0}}, w0_next};
        mem_wr_next       = lane8[3:0];
        mem_datain_next   = data64[31:0];
      end
      WR1: begin
        mem_waddress_next = {{(32-DM_ADDRESS){1'b0}}, w1_next};
        mem_wr_next       = lane8[7:4];
        mem_datain_next   = data64[63:32];
      end
      default: ;
    endcase
  end

  // An aligned load never needs bytes above word0, so its upper half is zero.
  always_comb begin
    word0_next = (state_reg == WT0) ? mem_dataout : word0_reg;
    ld_pair    = (state_reg == WT1) ? {mem_dataout, word0_reg} : {32'h0, mem_dataout};
    ld_word    = 32'(ld_pair >> shamt_reg);
    case (f3_reg)
      3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
      3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
      3'b100:  ld_ext = {24'h0, ld_word[7:0]};
      3'b101:  ld_ext = {16'h0, ld_word[15:0]};
      default: ld_ext = ld_word;
    endcase
  end

  // Only rejected requests jump from IDLE straight into RESP.
  always_comb begin
    rd_next       = '0;
    resp_err_next = 1'b0;
    if (state_next == RESP) begin
      if (state_reg == IDLE) resp_err_next = 1'b1;
      else if (is_load_reg)  rd_next = ld_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      is_load_reg      <= 1'b0;
      f3_reg           <= '0;
      off_reg          <= '0;
      w0_reg           <= '0;
      wd_reg           <= '0;
      word0_reg        <= '0;
      mem_raddress_reg <= '0;
      mem_waddress_reg <= '0;
      mem_datain_reg   <= '0;
      mem_wr_reg       <= '0;
      rd_reg           <= '0;
      resp_err_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      is_load_reg      <= is_load_next;
      f3_reg           <= f3_next;
      off_reg          <= off_next;
      w0_reg           <= w0_next;
      wd_reg           <= wd_next;
      word0_reg        <= word0_next;
      mem_raddress_reg <= mem_raddress_next;
      mem_waddress_reg <= mem_waddress_next;
      mem_datain_reg   <= mem_datain_next;
      mem_wr_reg       <= mem_wr_next;
      rd_reg           <= rd_next;
      resp_err_reg     <= resp_err_next;
    end
  end

  assign req_ready    = (state_reg == IDLE);
  assign resp_valid   = (state_reg == RESP);
  assign rd           = rd_reg;
  assign resp_err     = resp_err_reg;
  assign mem_raddress = mem_raddress_reg;
  assign mem_waddress = mem_waddress_reg;
  assign mem_datain   = mem_datain_reg;
  assign mem_wr       = mem_wr_reg;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator: word-organised memory model plus
// hand-computed expectations for aligned, misaligned, wrap, error and reset cases.
module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [8:0]  a;
  logic [31:0] wd;
  logic        resp_valid;
  logic [31:0] rd;
  logic        resp_err;
  logic [31:0] mem_raddress;
  logic [31:0] mem_waddress;
  logic [31:0] mem_datain;
  logic [3:0]  mem_wr;
  logic [31:0] mem_dataout;

  logic [31:0] mem [0:127] = '{default: 32'h0};

  int n_checks = 0;
  int n_fail   = 0;

  int          lat;
  logic [31:0] rd_obs;
  logic        err_obs;
  logic [31:0] raddr_log  [0:15];
  logic [31:0] waddr_log  [0:15];
  logic [31:0] datain_log [0:15];
  logic [3:0]  wr_log     [0:15];

  always #5 clk = ~clk;

  lsu_mem_initiator #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .Funct3       (Funct3),
    .a            (a),
    .wd           (wd),
    .resp_valid   (resp_valid),
    .rd           (rd),
    .resp_err     (resp_err),
    .mem_raddress (mem_raddress),
    .mem_waddress (mem_waddress),
    .mem_datain   (mem_datain),
    .mem_wr       (mem_wr),
    .mem_dataout  (mem_dataout)
  );

  // Synchronous-read data memory with byte-lane writes.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_wr[b]) mem[mem_waddress[8:2]][8*b +: 8] <= mem_datain[8*b +: 8];
    mem_dataout <= mem[mem_raddress[8:2]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_req(input string name, input logic r, input logic w, input logic [2:0] f3,
                        input logic [8:0] addr, input logic [31:0] data);
    for (int i = 0; i < 16; i++) begin
      raddr_log[i] = '0; waddr_log[i] = '0; datain_log[i] = '0; wr_log[i] = '0;
    end
    lat = 0; rd_obs = '0; err_obs = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; MemRead = r; MemWrite = w; Funct3 = f3; a = addr; wd = data;
    @(posedge clk);
    #1;
    // Garbage on the inputs while busy must not disturb the transaction.
    req_valid = 1'b0; MemRead = 1'b1; MemWrite = 1'b1; Funct3 = 3'b111;
    a = 9'h1FF; wd = 32'h5A5A5A5A;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      raddr_log[k] = mem_raddress; waddr_log[k] = mem_waddress;
      datain_log[k] = mem_datain;  wr_log[k] = mem_wr;
      if (resp_valid) begin
        lat = k; rd_obs = rd; err_obs = resp_err;
        break;
      end
    end
    MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000; a = '0; wd = '0;
    $display("txn %-5s a=0x%03h wd=0x%08h -> rd=0x%08h err=%0b latency=%0d",
             name, addr, data, rd_obs, err_obs, lat);
  endtask

  initial begin
    int resp_seen;
    rst_n = 1'b0; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    Funct3 = 3'b000; a = '0; wd = '0;
    #1;
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst rd", rd, 32'h0);
    check("rst resp_err", 32'(resp_err), 32'd0);
    check("rst mem_wr", 32'(mem_wr), 32'd0);
    check("rst raddr", mem_raddress, 32'h0);
    check("rst waddr", mem_waddress, 32'h0);
    check("rst datain", mem_datain, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Aligned word store and load
    do_req("SW", 1'b0, 1'b1, 3'b010, 9'h010, 32'hDEADBEEF);
    check("sw lat", 32'(lat), 32'd2);
    check("sw waddr", waddr_log[1], 32'h10);
    check("sw wr", 32'(wr_log[1]), 32'hF);
    check("sw datain", datain_log[1], 32'hDEADBEEF);
    check("sw wr resp", 32'(wr_log[2]), 32'h0);
    check("sw rd", rd_obs, 32'h0);
    do_req("LW", 1'b1, 1'b0, 3'b010, 9'h010, 32'h0);
    check("lw lat", 32'(lat), 32'd3);
    check("lw raddr", raddr_log[1], 32'h10);
    check("lw raddr hold", raddr_log[2], 32'h10);
    check("lw wr", 32'(wr_log[1] | wr_log[2]), 32'h0);
    check("lw rd", rd_obs, 32'hDEADBEEF);

    // Byte accesses
    do_req("SB", 1'b0, 1'b1, 3'b000, 9'h013, 32'h000000A5);
    check("sb lat", 32'(lat), 32'd2);
    check("sb wr", 32'(wr_log[1]), 32'h8);
    check("sb datain", datain_log[1], 32'hA5000000);
    check("sb mem", mem[4], 32'hA5ADBEEF);
    do_req("LB", 1'b1, 1'b0, 3'b000, 9'h013, 32'h0);
    check("lb rd", rd_obs, 32'hFFFFFFA5);
    do_req("LBU", 1'b1, 1'b0, 3'b100, 9'h013, 32'h0);
    check("lbu rd", rd_obs, 32'h000000A5);

    // Misaligned loads
    do_req("SW", 1'b0, 1'b1, 3'b010, 9'h004, 32'h44332211);
    do_req("SW", 1'b0, 1'b1, 3'b010, 9'h008, 32'h88776655);
    do_req("LW", 1'b1, 1'b0, 3'b010, 9'h006, 32'h0);
    check("lw mis lat", 32'(lat), 32'd5);
    check("lw mis raddr0", raddr_log[1], 32'h04);
    check("lw mis raddr1", raddr_log[3], 32'h08);
    check("lw mis rd", rd_obs, 32'h66554433);
    do_req("LH", 1'b1, 1'b0, 3'b001, 9'h007, 32'h0);
    check("lh mis rd", rd_obs, 32'h00005544);

    // Misaligned halfword store across words 0x08/0x0C
    do_req("SH", 1'b0, 1'b1, 3'b001, 9'h00B, 32'h0000F234);
    check("sh lat", 32'(lat), 32'd3);
    check("sh waddr0", waddr_log[1], 32'h08);
    check("sh wr0", 32'(wr_log[1]), 32'h8);
    check("sh datain0", datain_log[1], 32'h34000000);
    check("sh waddr1", waddr_log[2], 32'h0C);
    check("sh wr1", 32'(wr_log[2]), 32'h1);
    check("sh datain1", datain_log[2], 32'h000000F2);
    check("sh mem0", mem[2], 32'h34776655);
    check("sh mem1", mem[3], 32'h000000F2);
    do_req("LHU", 1'b1, 1'b0, 3'b101, 9'h00B, 32'h0);
    check("lhu mis rd", rd_obs, 32'h0000F234);

    // Wrap from the top word back to address 0
    do_req("SW", 1'b0, 1'b1, 3'b010, 9'h1FC, 32'hCAFEBABE);
    do_req("SW", 1'b0, 1'b1, 3'b010, 9'h000, 32'h12345678);
    do_req("LW", 1'b1, 1'b0, 3'b010, 9'h1FE, 32'h0);
    check("wrap raddr0", raddr_log[1], 32'h1FC);
    check("wrap raddr1", raddr_log[3], 32'h000);
    check("wrap rd", rd_obs, 32'h5678CAFE);

    // Rejected requests
    do_req("LERR", 1'b1, 1'b0, 3'b011, 9'h010, 32'h0);
    check("err f3 lat", 32'(lat), 32'd1);
    check("err f3 flag", 32'(err_obs), 32'd1);
    check("err f3 rd", rd_obs, 32'h0);
    check("err f3 wr", 32'(wr_log[1]), 32'h0);
    do_req("RWERR", 1'b1, 1'b1, 3'b010, 9'h010, 32'h11111111);
    check("err rw lat", 32'(lat), 32'd1);
    check("err rw flag", 32'(err_obs), 32'd1);
    check("err rw wr", 32'(wr_log[1]), 32'h0);
    do_req("SERR", 1'b0, 1'b1, 3'b100, 9'h010, 32'h22222222);
    check("err st flag", 32'(err_obs), 32'd1);
    check("err st mem", mem[4], 32'hA5ADBEEF);

    // Reset during WR1 of a misaligned store
    @(negedge clk);
    req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; Funct3 = 3'b001;
    a = 9'h00B; wd = 32'h0000ABCD;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2;
    check("rst mid wr1", 32'(mem_wr), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst mid wr drop", 32'(mem_wr), 32'h0);
    resp_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid) resp_seen++;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid) resp_seen++;
    end
    $display("txn RST   a=0x00b wd=0x0000abcd -> dropped, responses=%0d", resp_seen);
    check("rst mid no resp", 32'(resp_seen), 32'd0);
    check("rst mid ready", 32'(req_ready), 32'd1);
    check("rst mid mem0", mem[2], 32'hCD776655);
    check("rst mid mem1", mem[3], 32'h000000F2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
